// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between the ioctl
// loader (writes), the video line fetch (reads) and the refresh timer.
module sdram_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int REFRESH_CYCLES = 780,
    parameter int STARVE_MAX     = 8
) (
    input  logic              clk_ram,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid,
    output logic              ctl_req,
    output logic              ctl_we,
    output logic              ctl_refresh,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_ack,
    input  logic [DATA_W-1:0] ctl_rdata,
    input  logic              ctl_rvalid,
    output logic              busy
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [RW-1:0] RELOAD = RW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WR,
        ISSUE_RD,
        WAIT_RD,
        REFRESH
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              pend_q, pend_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              ctl_req_q, ctl_req_d;
    logic              ctl_we_q, ctl_we_d;
    logic              ctl_refresh_q, ctl_refresh_d;
    logic [ADDR_W-1:0] ctl_addr_q, ctl_addr_d;
    logic [DATA_W-1:0] ctl_wdata_q, ctl_wdata_d;
    logic              ld_ack_q, ld_ack_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        starve_d      = starve_q;
        ctl_req_d     = ctl_req_q;
        ctl_we_d      = ctl_we_q;
        ctl_refresh_d = ctl_refresh_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_wdata_d   = ctl_wdata_q;
        ld_ack_d      = 1'b0;
        vid_valid_d   = 1'b0;
        vid_rdata_d   = vid_rdata_q;

        if (rcnt_q == '0) begin
            rcnt_d = RELOAD;
        end else begin
            rcnt_d = rcnt_q - RW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d       = REFRESH;
                    ctl_req_d     = 1'b1;
                    ctl_we_d      = 1'b0;
                    ctl_refresh_d = 1'b1;
                end else if (ld_req && starve_q == SMAX) begin
                    state_d       = ISSUE_WR;
                    starve_d      = '0;
                    ctl_req_d     = 1'b1;
                    ctl_we_d      = 1'b1;
                    ctl_refresh_d = 1'b0;
                    ctl_addr_d    = ld_addr;
                    ctl_wdata_d   = ld_data;
                end else if (vid_req) begin
                    state_d       = ISSUE_RD;
                    ctl_req_d     = 1'b1;
                    ctl_we_d      = 1'b0;
                    ctl_refresh_d = 1'b0;
                    ctl_addr_d    = vid_addr;
                    // below SMAX here, so the increment saturates naturally
                    if (ld_req) begin
                        starve_d = starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (ld_req) begin
                    state_d       = ISSUE_WR;
                    starve_d      = '0;
                    ctl_req_d     = 1'b1;
                    ctl_we_d      = 1'b1;
                    ctl_refresh_d = 1'b0;
                    ctl_addr_d    = ld_addr;
                    ctl_wdata_d   = ld_data;
                end
            end
            ISSUE_WR: begin
                if (ctl_ack) begin
                    state_d   = IDLE;
                    ctl_req_d = 1'b0;
                    ld_ack_d  = 1'b1;
                end
            end
            ISSUE_RD: begin
                if (ctl_ack) begin
                    state_d   = WAIT_RD;
                    ctl_req_d = 1'b0;
                end
            end
            WAIT_RD: begin
                if (ctl_rvalid) begin
                    state_d     = IDLE;
                    vid_rdata_d = ctl_rdata;
                    vid_valid_d = 1'b1;
                end
            end
            REFRESH: begin
                if (ctl_ack) begin
                    state_d   = IDLE;
                    ctl_req_d = 1'b0;
                    pend_d    = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                ctl_req_d = 1'b0;
            end
        endcase

        // an expiry in the same cycle as the refresh ack keeps pending set
        if (rcnt_q == '0) begin
            pend_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rcnt_q        <= RELOAD;
            pend_q        <= 1'b0;
            starve_q      <= '0;
            ctl_req_q     <= 1'b0;
            ctl_we_q      <= 1'b0;
            ctl_refresh_q <= 1'b0;
            ctl_addr_q    <= '0;
            ctl_wdata_q   <= '0;
            ld_ack_q      <= 1'b0;
            vid_valid_q   <= 1'b0;
            vid_rdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            pend_q        <= pend_d;
            starve_q      <= starve_d;
            ctl_req_q     <= ctl_req_d;
            ctl_we_q      <= ctl_we_d;
            ctl_refresh_q <= ctl_refresh_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_wdata_q   <= ctl_wdata_d;
            ld_ack_q      <= ld_ack_d;
            vid_valid_q   <= vid_valid_d;
            vid_rdata_q   <= vid_rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign ld_ack      = ld_ack_q;
    assign vid_valid   = vid_valid_q;
    assign vid_rdata   = vid_rdata_q;
    assign ctl_req     = ctl_req_q;
    assign ctl_we      = ctl_we_q;
    assign ctl_refresh = ctl_refresh_q;
    assign ctl_addr    = ctl_addr_q;
    assign ctl_wdata   = ctl_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM controller model
// (programmable ack and read-data latency) and a command log.
module tb_sdram_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam byte CR = "R";
    localparam byte CW = "W";
    localparam byte CF = "F";

    logic          clk_ram = 1'b0;
    logic          reset_n = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          vid_valid;
    logic          ctl_req;
    logic          ctl_we;
    logic          ctl_refresh;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata;
    logic          ctl_ack = 1'b0;
    logic [DW-1:0] ctl_rdata = '0;
    logic          ctl_rvalid = 1'b0;
    logic          busy;

    always #5 clk_ram = ~clk_ram;

    sdram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .REFRESH_CYCLES(20),
        .STARVE_MAX(8)
    ) dut (
        .clk_ram(clk_ram),
        .reset_n(reset_n),
        .ld_req(ld_req),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_ack(ld_ack),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_rdata(vid_rdata),
        .vid_valid(vid_valid),
        .ctl_req(ctl_req),
        .ctl_we(ctl_we),
        .ctl_refresh(ctl_refresh),
        .ctl_addr(ctl_addr),
        .ctl_wdata(ctl_wdata),
        .ctl_ack(ctl_ack),
        .ctl_rdata(ctl_rdata),
        .ctl_rvalid(ctl_rvalid),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    bit            ack_en = 1'b1;
    int            ack_dly = 0;
    int            rd_dly = 1;
    int            ack_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] rd_data = '0;

    int  cyc = 0;
    int  n_ldack = 0;
    int  n_vvalid = 0;
    int  log_n = 0;
    int  nref = 0;
    byte cmd_log[64];
    int  ref_cyc[8];

    int ack_at, lda_at, vv_at, nlda, nvv, seq_n, nw, p;
    bit got;

    // controller model: acks ack_dly cycles after ctl_req, read data rd_dly after ack
    initial begin
        forever begin
            @(posedge clk_ram);
            #1;
            ctl_rvalid = 1'b0;
            if (!reset_n) begin
                ctl_ack = 1'b0;
                ack_cnt = 0;
                rd_cnt  = 0;
            end else begin
                if (rd_cnt != 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        ctl_rvalid = 1'b1;
                        ctl_rdata  = rd_data;
                    end
                end
                if (ctl_ack) begin
                    ctl_ack = 1'b0;
                    ack_cnt = 0;
                end else if (ctl_req && ack_en) begin
                    if (ack_cnt == ack_dly) begin
                        ctl_ack = 1'b1;
                        if (!ctl_refresh && !ctl_we) rd_cnt = rd_dly;
                    end else begin
                        ack_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_ram);
            cyc++;
            if (ld_ack) n_ldack++;
            if (vid_valid) n_vvalid++;
            if (reset_n && ctl_req && ctl_ack) begin
                if (log_n < 64) cmd_log[log_n] = ctl_refresh ? CF : (ctl_we ? CW : CR);
                log_n++;
                if (ctl_refresh && nref < 8) begin
                    ref_cyc[nref] = cyc;
                    nref++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_ram);
        #1;
    endtask

    task automatic clear_log();
        log_n = 0;
        nref = 0;
        n_ldack = 0;
        n_vvalid = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ld_req = 1'b0;
        vid_req = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        clear_log();
    endtask

    initial begin
        // reset with both requesters active
        ack_en = 1'b0;
        ld_req = 1'b1;
        vid_req = 1'b1;
        ld_addr = 25'h0000011;
        ld_data = 16'h0011;
        vid_addr = 25'h002AAAA;
        repeat (3) tick();
        check("rst_ctl_req", 32'(ctl_req), 0);
        check("rst_ld_ack", 32'(ld_ack), 0);
        check("rst_vid_valid", 32'(vid_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ctl_addr", 32'(ctl_addr), 0);
        check("rst_vid_rdata", 32'(vid_rdata), 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_req", 32'(ctl_req), 1);
        check("post_rst_we", 32'(ctl_we), 0);
        check("post_rst_addr", 32'(ctl_addr), 32'h002AAAA);
        check("post_rst_busy", 32'(busy), 1);
        ack_en = 1'b1;
        do_reset();

        // single write, ack 3 cycles after ctl_req
        ack_dly = 3;
        ld_addr = 25'h0000123;
        ld_data = 16'hBEEF;
        ld_req = 1'b1;
        ack_at = -1;
        lda_at = -1;
        nlda = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_at >= 0 && i == ack_at + 1) check("wr_req_drop", 32'(ctl_req), 0);
            if (ctl_req && ctl_ack && ack_at < 0) begin
                ack_at = i;
                check("wr_addr", 32'(ctl_addr), 32'h0000123);
                check("wr_wdata", 32'(ctl_wdata), 32'hBEEF);
                check("wr_we", 32'(ctl_we), 1);
                check("wr_refresh", 32'(ctl_refresh), 0);
            end
            if (ld_ack) begin
                nlda++;
                if (lda_at < 0) lda_at = i;
                ld_req = 1'b0;
            end
        end
        check("wr_acked", 32'(ack_at >= 0), 1);
        check("wr_ldack_count", nlda, 1);
        check("wr_ldack_latency", lda_at - ack_at, 1);
        do_reset();

        // read, data returned 4 cycles after ack
        ack_dly = 0;
        rd_dly = 4;
        rd_data = 16'h1234;
        vid_addr = 25'h0040000;
        vid_req = 1'b1;
        ack_at = -1;
        vv_at = -1;
        nvv = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (vv_at >= 0 && i == vv_at + 1) begin
                check("rd_pulse_end", 32'(vid_valid), 0);
                check("rd_busy_after", 32'(busy), 0);
            end
            if (ctl_req && ctl_ack && ack_at < 0) begin
                ack_at = i;
                check("rd_addr", 32'(ctl_addr), 32'h0040000);
                check("rd_we", 32'(ctl_we), 0);
            end
            if (vid_valid) begin
                nvv++;
                if (vv_at < 0) begin
                    vv_at = i;
                    check("rd_data", 32'(vid_rdata), 32'h1234);
                    check("rd_busy", 32'(busy), 0);
                end
                vid_req = 1'b0;
            end
        end
        check("rd_valid_count", nvv, 1);
        check("rd_latency", vv_at - ack_at, 5);
        check("rd_data_hold", 32'(vid_rdata), 32'h1234);
        do_reset();

        // starvation: both held, immediate acks
        ack_dly = 0;
        rd_dly = 1;
        ld_req = 1'b1;
        vid_req = 1'b1;
        seq_n = 0;
        for (int i = 0; i < 400 && seq_n < 17; i++) begin
            tick();
            seq_n = 0;
            for (int k = 0; k < log_n && k < 64; k++) begin
                if (cmd_log[k] != CF) seq_n++;
            end
        end
        check("starve_done", 32'(seq_n >= 17), 1);
        p = 0;
        nw = 0;
        for (int k = 0; k < log_n && k < 64; k++) begin
            if (cmd_log[k] != CF && p < 17) begin
                check($sformatf("starve_seq%0d", p), 32'(cmd_log[k]), (p == 8) ? 32'(CW) : 32'(CR));
                if (cmd_log[k] == CW) nw++;
                p++;
            end
        end
        check("starve_ldack_vs_grants", n_ldack, nw);
        do_reset();

        // refresh every 20 cycles on an idle bus
        for (int i = 0; i < 100 && nref < 3; i++) tick();
        check("ref_count", 32'(nref >= 3), 1);
        check("ref_interval1", ref_cyc[1] - ref_cyc[0], 20);
        check("ref_interval2", ref_cyc[2] - ref_cyc[1], 20);
        do_reset();

        // refresh goes ahead of a waiting write once the long read completes
        rd_dly = 30;
        rd_data = 16'h0F0F;
        vid_addr = 25'h0000200;
        ld_addr = 25'h0000300;
        ld_data = 16'hCAFE;
        vid_req = 1'b1;
        ld_req = 1'b1;
        for (int i = 0; i < 100 && log_n < 3; i++) begin
            tick();
            if (vid_valid) vid_req = 1'b0;
            if (ld_ack) ld_req = 1'b0;
        end
        check("rf_log_len", 32'(log_n >= 3), 1);
        check("rf_cmd0", 32'(cmd_log[0]), 32'(CR));
        check("rf_cmd1", 32'(cmd_log[1]), 32'(CF));
        check("rf_cmd2", 32'(cmd_log[2]), 32'(CW));
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ld_ack) ld_req = 1'b0;
        end
        ld_req = 1'b0;
        do_reset();

        // reset while waiting for read data
        rd_dly = 10;
        vid_addr = 25'h0000400;
        vid_req = 1'b1;
        for (int i = 0; i < 20 && log_n < 1; i++) tick();
        tick();
        tick();
        check("mr_busy", 32'(busy), 1);
        reset_n = 1'b0;
        vid_req = 1'b0;
        n_vvalid = 0;
        #1;
        check("mr_req_drop", 32'(ctl_req), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (15) tick();
        check("mr_no_valid", n_vvalid, 0);
        rd_dly = 2;
        rd_data = 16'h5A5A;
        vid_addr = 25'h1ABCDE;
        vid_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (vid_valid) begin
                got = 1'b1;
                vid_req = 1'b0;
                check("mr_fresh_data", 32'(vid_rdata), 32'h5A5A);
            end
        end
        check("mr_fresh_done", 32'(got), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between two requesters and the refresh timer.
- Requester 0 is the ioctl loader, which writes a ROM/program image during download.
- Requester 1 is the video line-fetch path, which reads pixel data.
- Sits inside bocks_top between the loader/video logic and the SDRAM controller, entirely in the clk_ram domain.

Parameters:
- ADDR_W, 25, SDRAM word address width
- DATA_W, 16, SDRAM data width
- REFRESH_CYCLES, 780, clk_ram cycles between refresh requests (~7.8 us at 100 MHz)
- STARVE_MAX, 8, consecutive video grants with loader waiting before the loader is forced a grant

Ports:
- clk_ram  in  1  RAM clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ld_req  in  1  loader write request; held until ld_ack
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle pulse: write accepted by controller
- vid_req  in  1  video read request; held until vid_valid
- vid_addr  in  ADDR_W  video read address
- vid_rdata  out  DATA_W  read data, valid with vid_valid
- vid_valid  out  1  one-cycle pulse: vid_rdata valid
- ctl_req  out  1  command request to controller
- ctl_we  out  1  1=write, 0=read (ignored when ctl_refresh=1)
- ctl_refresh  out  1  command is auto-refresh
- ctl_addr  out  ADDR_W  command address
- ctl_wdata  out  DATA_W  write data
- ctl_ack  in  1  controller accepted the command (one-cycle pulse)
- ctl_rdata  in  DATA_W  controller read data
- ctl_rvalid  in  1  ctl_rdata valid (one-cycle pulse, arrives after ctl_ack)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; state=IDLE.
  - refresh counter=REFRESH_CYCLES-1; refresh_pending=0; starve count=0.
  - Asserting reset mid-command drops ctl_req immediately. No ack or valid is generated for the aborted command.
- Refresh timer:
  - Free-running down-counter; on reaching 0 sets refresh_pending and reloads REFRESH_CYCLES-1.
  - Expiry while refresh_pending is already 1 leaves it at 1 (no accumulation).
  - refresh_pending clears on ctl_ack in REFRESH. If expiry coincides with that ack, pending stays 1.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD, REFRESH.
- IDLE arbitration, evaluated every cycle, first match wins:
  1. refresh_pending -> REFRESH.
  2. ld_req && starve==STARVE_MAX -> ISSUE_WR; starve<=0.
  3. vid_req -> ISSUE_RD; starve<=starve+1 if ld_req, else 0.
  4. ld_req -> ISSUE_WR; starve<=0.
  5. Otherwise stay in IDLE.
- Command registers (ctl_addr, ctl_wdata, ctl_we, ctl_refresh) load on the IDLE->issue transition. ctl_req rises the next cycle, i.e. one cycle of latency from request to ctl_req.
- ISSUE_WR / ISSUE_RD / REFRESH: ctl_req=1 with fields held stable until ctl_ack.
  - On ack, ctl_req drops the following cycle.
  - ISSUE_WR: ld_ack pulses one cycle after ctl_ack -> IDLE.
  - ISSUE_RD -> WAIT_RD.
  - REFRESH -> IDLE.
- WAIT_RD: on ctl_rvalid, capture ctl_rdata into vid_rdata and pulse vid_valid the next cycle -> IDLE. vid_rdata holds its value until the next read.
- A requester dropping its req before ack is a protocol violation. The arbiter completes the issued command anyway and still pulses ack/valid.
- Only one command is outstanding at a time; ctl_ack outside the ISSUE/REFRESH states is ignored.
- starve saturates at STARVE_MAX.
- Worst-case loader wait: STARVE_MAX video commands plus one refresh.

Test Plan:
- Reset: hold reset_n=0 with ld_req=vid_req=1 -> all outputs 0. After release, ctl_req=1 at cycle 2 with ctl_we=0 (video wins).
- Single write: ld_req, ld_addr=0x000123, ld_data=0xBEEF; controller acks 3 cycles after ctl_req -> ctl_addr=0x000123, ctl_wdata=0xBEEF, ctl_we=1; ld_ack pulses exactly once, 1 cycle after ctl_ack.
- Read: vid_addr=0x040000; controller returns ctl_rdata=0x1234 4 cycles after ack -> vid_rdata=0x1234; vid_valid is a single-cycle pulse; busy=0 the following cycle.
- Starvation: vid_req and ld_req held continuously with immediate acks -> 8 reads, then 1 write, then 8 reads. ld_ack count equals write grants.
- Refresh: REFRESH_CYCLES=20 with an idle bus -> ctl_refresh=1 requested every 20 cycles. With a read in flight, refresh is issued immediately after that read completes and before any pending ld_req.
- Reset mid-read: assert reset_n=0 in WAIT_RD -> ctl_req=0 and vid_valid never pulses. After release, a fresh vid_req completes normally.
